retire_multibranch: RTL and testbench

Parametrised in-order commit stage between the ROB head window and the architectural state: arch map table, freelist, fetch redirect and branch predictor training. Each cycle it retires up to `W` complete instructions, including up to `MAX_BR` correctly predicted branches. It stops at the first incomplete entry, the first mispredicted branch, or a halt. A three-state controller sequences recovery and stop: a post-mispredict flush window and a terminal halted state. A committed freelist checkpoint provides the mispredict restore.

---
 rtl/retire_multibranch_if.sv | 112 +++++++++++
 rtl/retire_multibranch.sv | 220 ++++++++++++++++++++++
 tb/tb_retire_multibranch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/retire_multibranch_if.sv
// Shared types and the ROB-head / commit-side bus of the multi-branch retire stage.
// Optional perf ports are present when RETIRE_PERF_EN is defined.
`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

package retire_multibranch_pkg;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned PHYS_TAG_W = $clog2(`PHYS_REG_SZ_R10K);
  localparam int unsigned ROB_IDX_W  = 5;
  localparam int unsigned GHR_W      = 8;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
  typedef logic [GHR_W-1:0]      ghr_t;

  typedef struct packed {
    addr_t     pc;
    logic      complete;
    logic      is_branch;
    logic      branch_taken;
    addr_t     branch_target;
    logic      pred_taken;
    addr_t     pred_target;
    logic      halt;
    logic      illegal;
    reg_idx_t  arch_rd;
    phys_tag_t phys_rd;
    phys_tag_t prev_phys_rd;
    ghr_t      ghr_snapshot;
  } rob_entry_t;

  typedef struct packed {
    logic  valid;
    addr_t pc;
    logic  actual_taken;
    addr_t actual_target;
    ghr_t  ghr_snapshot;
    logic  mispredict;
  } bp_train_req_t;

  typedef struct packed {
    addr_t    npc;
    data_t    data;
    reg_idx_t reg_idx;
    logic     halt;
    logic     illegal;
    logic     valid;
  } commit_packet_t;
endpackage

interface retire_multibranch_if
  import retire_multibranch_pkg::*;
#(
  parameter int unsigned W         = `N,
  parameter int unsigned MAX_BR    = 2,
  parameter int unsigned PHYS_REGS = `PHYS_REG_SZ_R10K
);
  localparam int unsigned CNT_W = $clog2(W + 1);

  rob_entry_t           head_entries [W];
  logic [W-1:0]         head_valids;
  rob_idx_t             head_idxs [W];
  logic [CNT_W-1:0]     retire_count;
  logic [W-1:0]         arch_we;
  reg_idx_t             arch_addr [W];
  phys_tag_t            arch_tag [W];
  logic [PHYS_REGS-1:0] free_mask;
  logic [PHYS_REGS-1:0] freelist_restore_mask;
  logic                 mispredict;
  rob_idx_t             mispred_idx;
  addr_t                redirect_pc;
  bp_train_req_t        train_req [MAX_BR];
  commit_packet_t       committed_insts [W];
  data_t                regfile_entries [PHYS_REGS];
  logic                 halted;
`ifdef RETIRE_PERF_EN
  logic [31:0]          perf_committed;
  logic [31:0]          perf_branches;
  logic [31:0]          perf_mispredicts;
  logic [31:0]          perf_flush_cycles;
`endif

  modport master (
    output head_entries, head_valids, head_idxs, regfile_entries,
    input  retire_count, arch_we, arch_addr, arch_tag, free_mask, freelist_restore_mask,
    input  mispredict, mispred_idx, redirect_pc, train_req, committed_insts, halted
`ifdef RETIRE_PERF_EN
    , input perf_committed, perf_branches, perf_mispredicts, perf_flush_cycles
`endif
  );

  modport slave (
    input  head_entries, head_valids, head_idxs, regfile_entries,
    output retire_count, arch_we, arch_addr, arch_tag, free_mask, freelist_restore_mask,
    output mispredict, mispred_idx, redirect_pc, train_req, committed_insts, halted
`ifdef RETIRE_PERF_EN
    , output perf_committed, perf_branches, perf_mispredicts, perf_flush_cycles
`endif
  );
endinterface

// File: rtl/retire_multibranch.sv
// In-order multi-lane commit with branch training, mispredict flush window and halt.
// Define RETIRE_PERF_EN to add saturating performance counters.
module retire_multibranch
  import retire_multibranch_pkg::*;
#(
  parameter int unsigned W            = `N,
  parameter int unsigned MAX_BR       = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PHYS_REGS    = `PHYS_REG_SZ_R10K,
  parameter int unsigned ARCH_REGS    = `ARCH_REG_SZ
) (
  input logic                 clock,
  input logic                 reset,
  retire_multibranch_if.slave rt
);
  localparam int unsigned CNT_W  = $clog2(W + 1);
  localparam int unsigned FCNT_W = 4;
  localparam logic [PHYS_REGS-1:0] INIT_MASK = {PHYS_REGS{1'b1}} << ARCH_REGS;

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_e;

  state_e               state_q, state_d;
  logic [FCNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                 halted_q, halted_d;
  logic [W-1:0]         arch_we_q, arch_we_d;
  reg_idx_t             arch_addr_q [W];
  reg_idx_t             arch_addr_d [W];
  phys_tag_t            arch_tag_q [W];
  phys_tag_t            arch_tag_d [W];
  logic [PHYS_REGS-1:0] free_q, free_d, ckpt_q, ckpt_d;
  logic                 mispredict_q, mispredict_d;
  rob_idx_t             mispred_idx_q, mispred_idx_d;
  addr_t                redirect_q, redirect_d;
  bp_train_req_t        train_q [MAX_BR];
  bp_train_req_t        train_d [MAX_BR];
  commit_packet_t       commit_q [W];
  commit_packet_t       commit_d [W];
  logic [CNT_W-1:0]     retire_count_c;

  // Head-window scan plus controller next-state
  always_comb begin
    rob_entry_t  e;
    logic        stop;
    logic        mis;
    int unsigned br_cnt;
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    halted_d       = halted_q;
    arch_we_d      = '0;
    free_d         = '0;
    ckpt_d         = ckpt_q;
    mispredict_d   = 1'b0;
    mispred_idx_d  = '0;
    redirect_d     = '0;
    retire_count_c = '0;
    e              = '0;
    stop           = 1'b0;
    mis            = 1'b0;
    br_cnt         = 0;
    for (int i = 0; i < W; i++) begin
      arch_addr_d[i] = '0;
      arch_tag_d[i]  = '0;
      commit_d[i]    = '0;
    end
    for (int s = 0; s < MAX_BR; s++) train_d[s] = '0;

    case (state_q)
      RUN: begin
        for (int i = 0; i < W; i++) begin
          e   = rt.head_entries[i];
          mis = e.is_branch && ((e.pred_taken != e.branch_taken) ||
                                (e.branch_taken && (e.pred_target != e.branch_target)));
          if (!stop && rt.head_valids[i]) begin
            if (!e.complete || (e.is_branch && br_cnt == MAX_BR)) begin
              stop = 1'b1;
            end else begin
              retire_count_c      = CNT_W'(i + 1);
              commit_d[i].npc     = e.pc + ADDR_W'(4);
              commit_d[i].data    = rt.regfile_entries[e.phys_rd];
              commit_d[i].reg_idx = e.is_branch ? '0 : e.arch_rd;
              commit_d[i].halt    = e.halt;
              commit_d[i].illegal = e.illegal;
              commit_d[i].valid   = 1'b1;
              if (e.is_branch) begin
                for (int unsigned s = 0; s < MAX_BR; s++) begin
                  if (s == br_cnt) begin
                    train_d[s].valid         = 1'b1;
                    train_d[s].pc            = e.pc;
                    train_d[s].actual_taken  = e.branch_taken;
                    train_d[s].actual_target = e.branch_target;
                    train_d[s].ghr_snapshot  = e.ghr_snapshot;
                    train_d[s].mispredict    = mis;
                  end
                end
                br_cnt++;
              end else if (e.arch_rd != '0) begin
                arch_we_d[i]   = 1'b1;
                arch_addr_d[i] = e.arch_rd;
                arch_tag_d[i]  = e.phys_rd;
                // Tag 0 is never freed; tags at or above PHYS_REGS never match
                for (int unsigned j = 0; j < PHYS_REGS; j++) begin
                  if (e.phys_rd == PHYS_TAG_W'(j)) ckpt_d[j] = 1'b0;
                  if (j != 0 && e.prev_phys_rd == PHYS_TAG_W'(j)) begin
                    free_d[j] = 1'b1;
                    ckpt_d[j] = 1'b1;
                  end
                end
              end
              if (mis) begin
                stop          = 1'b1;
                mispredict_d  = 1'b1;
                mispred_idx_d = rt.head_idxs[i];
                redirect_d    = e.branch_taken ? e.branch_target : e.pc + ADDR_W'(4);
                state_d       = FLUSH;
                flush_cnt_d   = FCNT_W'(FLUSH_CYCLES);
              end else if (e.halt) begin
                stop     = 1'b1;
                state_d  = HALTED;
                halted_d = 1'b1;
              end
            end
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= FCNT_W'(1)) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FCNT_W'(1);
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      halted_q      <= 1'b0;
      arch_we_q     <= '0;
      arch_addr_q   <= '{default: '0};
      arch_tag_q    <= '{default: '0};
      free_q        <= '0;
      ckpt_q        <= INIT_MASK;
      mispredict_q  <= 1'b0;
      mispred_idx_q <= '0;
      redirect_q    <= '0;
      train_q       <= '{default: '0};
      commit_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      halted_q      <= halted_d;
      arch_we_q     <= arch_we_d;
      arch_addr_q   <= arch_addr_d;
      arch_tag_q    <= arch_tag_d;
      free_q        <= free_d;
      ckpt_q        <= ckpt_d;
      mispredict_q  <= mispredict_d;
      mispred_idx_q <= mispred_idx_d;
      redirect_q    <= redirect_d;
      train_q       <= train_d;
      commit_q      <= commit_d;
    end
  end

  // ROB must not pop while the stage itself is being reset
  assign rt.retire_count          = reset ? '0 : retire_count_c;
  assign rt.arch_we               = arch_we_q;
  assign rt.arch_addr             = arch_addr_q;
  assign rt.arch_tag              = arch_tag_q;
  assign rt.free_mask             = free_q;
  assign rt.freelist_restore_mask = ckpt_q;
  assign rt.mispredict            = mispredict_q;
  assign rt.mispred_idx           = mispred_idx_q;
  assign rt.redirect_pc           = redirect_q;
  assign rt.train_req             = train_q;
  assign rt.committed_insts       = commit_q;
  assign rt.halted                = halted_q;

`ifdef RETIRE_PERF_EN
  logic [31:0] perf_committed_q, perf_branches_q, perf_mispredicts_q, perf_flush_q;
  logic [31:0] n_commit_c, n_br_c;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  always_comb begin
    n_commit_c = '0;
    n_br_c     = '0;
    for (int i = 0; i < W; i++) n_commit_c = n_commit_c + 32'(commit_d[i].valid);
    for (int s = 0; s < MAX_BR; s++) n_br_c = n_br_c + 32'(train_d[s].valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_committed_q   <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
      perf_flush_q       <= '0;
    end else begin
      perf_committed_q   <= sat_add(perf_committed_q, n_commit_c);
      perf_branches_q    <= sat_add(perf_branches_q, n_br_c);
      perf_mispredicts_q <= sat_add(perf_mispredicts_q, 32'(mispredict_d));
      perf_flush_q       <= sat_add(perf_flush_q, 32'(state_q == FLUSH));
    end
  end

  assign rt.perf_committed    = perf_committed_q;
  assign rt.perf_branches     = perf_branches_q;
  assign rt.perf_mispredicts  = perf_mispredicts_q;
  assign rt.perf_flush_cycles = perf_flush_q;
`endif
endmodule

// File: tb/tb_retire_multibranch.sv
// Directed bench for retire_multibranch at W=4, MAX_BR=2, FLUSH_CYCLES=2, 64/32 regs.
module tb_retire_multibranch;
  import retire_multibranch_pkg::*;

  localparam logic [63:0] INIT = 64'hFFFF_FFFF_0000_0000;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  retire_multibranch_if #(.W(4), .MAX_BR(2), .PHYS_REGS(64)) rt ();

  retire_multibranch #(
    .W(4), .MAX_BR(2), .FLUSH_CYCLES(2), .PHYS_REGS(64), .ARCH_REGS(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rt   (rt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic rob_entry_t alu(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [5:0] prd, input logic [5:0] told);
    rob_entry_t e;
    e = '0;
    e.pc = pc; e.complete = 1'b1; e.arch_rd = rd; e.phys_rd = prd; e.prev_phys_rd = told;
    return e;
  endfunction

  function automatic rob_entry_t br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                    input logic ptk, input logic [31:0] ptgt);
    rob_entry_t e;
    e = '0;
    e.pc = pc; e.complete = 1'b1; e.is_branch = 1'b1; e.branch_taken = tk;
    e.branch_target = tgt; e.pred_taken = ptk; e.pred_target = ptgt; e.ghr_snapshot = 8'h5A;
    return e;
  endfunction

  task automatic set_lane(input logic [1:0] i, input rob_entry_t e);
    rt.head_entries[i] = e;
    rt.head_valids[i]  = 1'b1;
  endtask

  task automatic clear_head();
    rt.head_valids = '0;
    for (int i = 0; i < 4; i++) begin
      rt.head_entries[i] = '0;
      rt.head_idxs[i]    = 5'(10 + i);
    end
  endtask

  initial begin
    rob_entry_t e;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_head();
    for (int j = 0; j < 64; j++) rt.regfile_entries[j] = 32'h1000 + 32'(j);
    repeat (2) @(posedge clock);
    #1;
    check("rst_restore", rt.freelist_restore_mask, INIT);
    check("rst_free", rt.free_mask, 64'd0);
    check("rst_halted", 64'(rt.halted), 64'd0);
    check("rst_misp", 64'(rt.mispredict), 64'd0);
    check("rst_we", 64'(rt.arch_we), 64'd0);
    reset = 1'b0;

    // four ALU lanes
    for (int i = 0; i < 4; i++)
      set_lane(2'(i), alu(32'h100 + 32'(4 * i), 5'(1 + i), 6'(40 + i), 6'(33 + i)));
    #1 check("t1_rc", 64'(rt.retire_count), 64'd4);
    tick();
    check("t1_we", 64'(rt.arch_we), 64'hF);
    check("t1_addr2", 64'(rt.arch_addr[2]), 64'd3);
    check("t1_tag3", 64'(rt.arch_tag[3]), 64'd43);
    check("t1_free", rt.free_mask, 64'h0000_001E_0000_0000);
    check("t1_restore", rt.freelist_restore_mask, 64'hFFFF_F0FF_0000_0000);
    check("t1_npc1", 64'(rt.committed_insts[1].npc), 64'h108);
    check("t1_data1", 64'(rt.committed_insts[1].data), 64'h1029);
    clear_head();
    tick();
    check("t1_we_pulse", 64'(rt.arch_we), 64'd0);
    check("t1_free_pulse", rt.free_mask, 64'd0);
    check("t1_restore_hold", rt.freelist_restore_mask, 64'hFFFF_F0FF_0000_0000);

    // incomplete lane 1 stops the scan
    set_lane(2'd0, alu(32'h200, 5'd5, 6'd44, 6'd5));
    e = alu(32'h204, 5'd6, 6'd45, 6'd6);
    e.complete = 1'b0;
    set_lane(2'd1, e);
    set_lane(2'd2, alu(32'h208, 5'd7, 6'd46, 6'd7));
    set_lane(2'd3, alu(32'h20C, 5'd8, 6'd47, 6'd8));
    #1 check("t2_rc", 64'(rt.retire_count), 64'd1);
    tick();
    check("t2_we", 64'(rt.arch_we), 64'h1);
    check("t2_free", rt.free_mask, 64'h20);
    check("t2_restore", rt.freelist_restore_mask, 64'hFFFF_E0FF_0000_0020);
    check("t2_valid1", 64'(rt.committed_insts[1].valid), 64'd0);

    // three correct branches, only two may retire
    clear_head();
    e = br(32'h300, 1'b0, 32'h380, 1'b0, 32'h0);
    e.arch_rd = 5'd9;
    set_lane(2'd0, e);
    set_lane(2'd1, br(32'h304, 1'b1, 32'h390, 1'b1, 32'h390));
    set_lane(2'd2, br(32'h308, 1'b0, 32'h3A0, 1'b0, 32'h0));
    #1 check("t3_rc", 64'(rt.retire_count), 64'd2);
    tick();
    check("t3_tr0_v", 64'(rt.train_req[0].valid), 64'd1);
    check("t3_tr0_pc", 64'(rt.train_req[0].pc), 64'h300);
    check("t3_tr0_ghr", 64'(rt.train_req[0].ghr_snapshot), 64'h5A);
    check("t3_tr1_pc", 64'(rt.train_req[1].pc), 64'h304);
    check("t3_tr1_tk", 64'(rt.train_req[1].actual_taken), 64'd1);
    check("t3_tr1_tgt", 64'(rt.train_req[1].actual_target), 64'h390);
    check("t3_misp", 64'(rt.mispredict), 64'd0);
    check("t3_we", 64'(rt.arch_we), 64'd0);
    check("t3_regidx0", 64'(rt.committed_insts[0].reg_idx), 64'd0);
    check("t3_valid2", 64'(rt.committed_insts[2].valid), 64'd0);

    // mispredict in lane 1, then flush window
    clear_head();
    set_lane(2'd0, alu(32'h400, 5'd8, 6'd47, 6'd6));
    set_lane(2'd1, br(32'h404, 1'b1, 32'h200, 1'b0, 32'h0));
    set_lane(2'd2, alu(32'h408, 5'd9, 6'd48, 6'd9));
    set_lane(2'd3, alu(32'h40C, 5'd10, 6'd49, 6'd10));
    #1 check("t4_rc", 64'(rt.retire_count), 64'd2);
    tick();
    check("t4_misp", 64'(rt.mispredict), 64'd1);
    check("t4_redirect", 64'(rt.redirect_pc), 64'h200);
    check("t4_idx", 64'(rt.mispred_idx), 64'd11);
    check("t4_tr0_misp", 64'(rt.train_req[0].mispredict), 64'd1);
    check("t4_we", 64'(rt.arch_we), 64'h1);
    check("t4_rc_flush1", 64'(rt.retire_count), 64'd0);
    for (int i = 0; i < 4; i++)
      set_lane(2'(i), alu(32'h500 + 32'(4 * i), 5'(10 + i), 6'(50 + i), 6'd0));
    #1 check("t4_rc_flush1b", 64'(rt.retire_count), 64'd0);
    tick();
    check("t4_misp_pulse", 64'(rt.mispredict), 64'd0);
    check("t4_rc_flush2", 64'(rt.retire_count), 64'd0);
    tick();
    check("t4_rc_run", 64'(rt.retire_count), 64'd4);
    tick();
    check("t4_we_run", 64'(rt.arch_we), 64'hF);
    check("t4_free_told0", rt.free_mask, 64'd0);

    // halt in lane 2
    clear_head();
    for (int i = 0; i < 4; i++)
      set_lane(2'(i), alu(32'h600 + 32'(4 * i), 5'(20 + i), 6'(54 + i), 6'(20 + i)));
    rt.head_entries[2].halt = 1'b1;
    #1 check("t5_rc", 64'(rt.retire_count), 64'd3);
    tick();
    check("t5_halted", 64'(rt.halted), 64'd1);
    check("t5_halt2", 64'(rt.committed_insts[2].halt), 64'd1);
    check("t5_valid3", 64'(rt.committed_insts[3].valid), 64'd0);
    check("t5_we", 64'(rt.arch_we), 64'h7);
    check("t5_rc_halt1", 64'(rt.retire_count), 64'd0);
    tick();
    check("t5_rc_halt2", 64'(rt.retire_count), 64'd0);
    check("t5_halted2", 64'(rt.halted), 64'd1);
    check("t5_we_halt", 64'(rt.arch_we), 64'd0);

    // reset while halted, then ten cycles of full retire
    for (int i = 0; i < 4; i++)
      set_lane(2'(i), alu(32'h700 + 32'(4 * i), 5'(1 + i), 6'(40 + i), 6'(33 + i)));
    reset = 1'b1;
    tick();
    check("t6_restore", rt.freelist_restore_mask, INIT);
    check("t6_halted", 64'(rt.halted), 64'd0);
    check("t6_we", 64'(rt.arch_we), 64'd0);
    check("t6_misp", 64'(rt.mispredict), 64'd0);
    reset = 1'b0;
    #1 check("t6_rc", 64'(rt.retire_count), 64'd4);
    for (int k = 0; k < 10; k++) tick();
    check("t6_we_run", 64'(rt.arch_we), 64'hF);
`ifdef RETIRE_PERF_EN
    check("perf_committed", 64'(rt.perf_committed), 64'd40);
    check("perf_branches", 64'(rt.perf_branches), 64'd0);
    check("perf_mispredicts", 64'(rt.perf_mispredicts), 64'd0);
    check("perf_flush", 64'(rt.perf_flush_cycles), 64'd0);
`endif

    // invalid lanes before a commit still count toward retire_count
    clear_head();
    set_lane(2'd1, alu(32'h800, 5'd12, 6'd60, 6'd7));
    #1 check("t7_rc", 64'(rt.retire_count), 64'd2);
    tick();
    check("t7_we", 64'(rt.arch_we), 64'h2);
    check("t7_free", rt.free_mask, 64'h80);
    clear_head();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
